// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: widths, bubble encoding, fetch FSM
// states and the instruction field positions used by decode control.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // state | meaning
  // ISSUE | no request outstanding; request PCF when allowed
  // WAIT  | one request granted, waiting for its rvalid
  typedef enum logic {
    ISSUE = 1'b0,
    WAIT  = 1'b1
  } fetch_state_e;

  localparam int OP_LSB   = 0;
  localparam int OP_MSB   = 6;
  localparam int F3_LSB   = 12;
  localparam int F3_MSB   = 14;
  localparam int F7B5_BIT = 30;

endpackage

// File: rtl/dff_en_rst.sv
// Enable flop with asynchronous active-high reset to a parameterised value.
module dff_en_rst #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // Load on enable, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       o_q <= RST_VAL;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register that catches a response the
// IF/ID register could not take in the cycle it arrived.
module fetch_skid_buffer
  import riscv_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [31:0]   i_instr,
  input  logic [AW-1:0] i_pc,
  output logic          o_full,
  output logic [31:0]   o_instr,
  output logic [AW-1:0] o_pc
);

  logic          r_full;
  logic [31:0]   r_instr;
  logic [AW-1:0] r_pc;

  // Flush wins over push; push and pop never coincide because no request is
  // outstanding while the entry is occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full  <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_push) begin
      r_full  <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// RISC-V instruction fetch: owns PCF, runs a single-outstanding req/gnt/rvalid
// transaction to instruction memory, and fills the IF/ID register, with a
// one-entry skid buffer for responses that arrive while Decode is stalled.
module fetch_stage #(
  parameter int          XLEN      = riscv_pkg::XLEN,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [6:0]      opD,
  output logic [2:0]      funct3D,
  output logic            funct7b5D
);

  import riscv_pkg::*;

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pcf, w_pcf_nxt;
  logic [XLEN-1:0] r_pc_inflight, w_pc_inflight_nxt;
  logic            r_drop, w_drop_nxt;
  logic            w_req;

  logic            w_buf_full;
  logic [31:0]     w_buf_instr;
  logic [XLEN-1:0] w_buf_pc;

  // A response is live only in WAIT, when it is not the stale one left over
  // from a redirect, and when no redirect is killing it this cycle.
  logic w_resp_live, w_ifid_from_buf, w_ifid_from_resp, w_push;
  assign w_resp_live      = (r_state == WAIT) && imem_rvalid && !r_drop && !PCSrcE;
  assign w_ifid_from_buf  = !FlushD && !StallD && w_buf_full;
  assign w_ifid_from_resp = !FlushD && !StallD && !w_buf_full && w_resp_live;
  assign w_push           = w_resp_live && !w_ifid_from_resp;

  // State register: FSM state, PC, in-flight PC and stale-response flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ISSUE;
      r_pcf         <= RESET_PC;
      r_pc_inflight <= '0;
      r_drop        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pcf         <= w_pcf_nxt;
      r_pc_inflight <= w_pc_inflight_nxt;
      r_drop        <= w_drop_nxt;
    end
  end

  // Next-state and request logic; a consumed response may reissue in the same
  // cycle so a 1-cycle memory sustains one instruction per cycle.
  always_comb begin
    w_state_nxt       = r_state;
    w_pcf_nxt         = r_pcf;
    w_pc_inflight_nxt = r_pc_inflight;
    w_drop_nxt        = r_drop;
    w_req             = 1'b0;
    case (r_state)
      ISSUE: w_req = !StallF && !w_buf_full && !PCSrcE;
      WAIT: begin
        if (imem_rvalid) begin
          w_drop_nxt  = 1'b0;
          w_state_nxt = ISSUE;
          w_req       = w_ifid_from_resp && !StallF && !PCSrcE;
        end else if (PCSrcE) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ISSUE;
    endcase
    if (w_req && !reset && imem_gnt) begin
      w_pc_inflight_nxt = r_pcf;
      w_pcf_nxt         = r_pcf + XLEN'(4);
      w_state_nxt       = WAIT;
    end
    if (PCSrcE) w_pcf_nxt = PCTargetE;
  end

  assign imem_req  = w_req && !reset;
  assign imem_addr = r_pcf;

  fetch_skid_buffer #(.AW(XLEN)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_ifid_from_buf),
    .i_flush (PCSrcE),
    .i_instr (imem_rdata),
    .i_pc    (r_pc_inflight),
    .o_full  (w_buf_full),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );

  // IF/ID: instruction/valid load on flush or no stall (bubble by default);
  // PC fields change only when a real instruction is loaded.
  logic            w_ifid_instr_en, w_ifid_pc_en, w_ifid_valid_d;
  logic [31:0]     w_ifid_instr_d;
  logic [XLEN-1:0] w_ifid_pc_d;
  assign w_ifid_instr_en = FlushD || !StallD;
  assign w_ifid_pc_en    = w_ifid_from_buf || w_ifid_from_resp;
  assign w_ifid_valid_d  = w_ifid_from_buf || w_ifid_from_resp;
  assign w_ifid_instr_d  = w_ifid_from_buf  ? w_buf_instr :
                           w_ifid_from_resp ? imem_rdata  : NOP_INSTR;
  assign w_ifid_pc_d     = w_ifid_from_buf ? w_buf_pc : r_pc_inflight;

  dff_en_rst #(.W(32), .RST_VAL(NOP_INSTR)) u_ifid_instr (
    .clk(clk), .rst(reset), .i_en(w_ifid_instr_en), .i_d(w_ifid_instr_d), .o_q(InstrD));
  dff_en_rst #(.W(1), .RST_VAL(1'b0)) u_ifid_valid (
    .clk(clk), .rst(reset), .i_en(w_ifid_instr_en), .i_d(w_ifid_valid_d), .o_q(ValidD));
  dff_en_rst #(.W(XLEN), .RST_VAL('0)) u_ifid_pc (
    .clk(clk), .rst(reset), .i_en(w_ifid_pc_en), .i_d(w_ifid_pc_d), .o_q(PCD));
  dff_en_rst #(.W(XLEN), .RST_VAL('0)) u_ifid_pc4 (
    .clk(clk), .rst(reset), .i_en(w_ifid_pc_en), .i_d(w_ifid_pc_d + XLEN'(4)), .o_q(PCPlus4D));

  assign opD       = InstrD[OP_MSB:OP_LSB];
  assign funct3D   = InstrD[F3_MSB:F3_LSB];
  assign funct7b5D = InstrD[F7B5_BIT];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a latency-programmable instruction
// memory returns PC-tagged words, and a scoreboard of expected PCD values is
// compared against each newly loaded valid IF/ID entry.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, funct7b5D;
  logic [6:0]  opD;
  logic [2:0]  funct3D;

  logic        gnt_en = 1'b1;
  int          lat = 1;
  logic        inj_rvalid = 1'b0;
  logic [31:0] inj_rdata = '0;
  logic        m_rv, m_pend;
  logic [31:0] m_rdata, m_addr;
  int          m_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb[$];
  logic        ld = 1'b1;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D));

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[9:2], 1'b0, a[6:2], 2'b11};
  endfunction

  assign imem_gnt    = gnt_en;
  assign imem_rvalid = m_rv | inj_rvalid;
  assign imem_rdata  = inj_rvalid ? inj_rdata : m_rdata;

  // Memory: response lat cycles after the grant, cleared by the shared reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rv <= 1'b0; m_pend <= 1'b0; m_cnt <= 0; m_rdata <= '0; m_addr <= '0;
    end else begin
      m_rv <= 1'b0;
      if (imem_req && imem_gnt) begin
        m_addr <= imem_addr;
        if (lat == 1) begin
          m_rv <= 1'b1; m_rdata <= instr_of(imem_addr);
        end else begin
          m_pend <= 1'b1; m_cnt <= lat - 1;
        end
      end else if (m_pend) begin
        if (m_cnt == 1) begin
          m_rv <= 1'b1; m_rdata <= instr_of(m_addr); m_pend <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic step;
    ld = FlushD || !StallD;
    @(negedge clk);
  endtask

  task automatic do_reset;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    gnt_en = 1; lat = 1; inj_rvalid = 0; inj_rdata = '0;
    sb.delete();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0 || ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: req=%b ValidD=%b InstrD=%h PCD=%h PCPlus4D=%h, expected 0 0 %h 0 0",
               imem_req, ValidD, InstrD, PCD, PCPlus4D, NOP);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] e, w;
    int first = -1;
    do_reset();
    for (int i = 0; i < 5; i++) sb.push_back(32'(i * 4));
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL seq_first_req: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      if (ValidD && first < 0) first = k;
      if (ValidD && ld) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL seq_extra: PCD=%h, none expected", PCD);
        end else begin
          e = sb.pop_front(); w = instr_of(e);
          if (PCD !== e || PCPlus4D !== e + 32'd4 || InstrD !== w || opD !== w[6:0] || funct3D !== w[14:12] || funct7b5D !== w[30]) begin
            n_bad++; $display("FAIL seq_data: PCD=%h PC4=%h InstrD=%h op=%h, expected PCD=%h InstrD=%h", PCD, PCPlus4D, InstrD, opD, e, w);
          end
        end
      end
    end
    n_cmp++;
    if (first !== 2) begin
      n_bad++; $display("FAIL seq_latency: first valid at cycle %0d, expected 2", first);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL seq_missing: %0d entries left, expected 0", sb.size());
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e, w;
    do_reset();
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    for (int k = 1; k <= 8; k++) begin
      step();
      if (ValidD && ld) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL bp_extra: PCD=%h, none expected", PCD);
        end else begin
          e = sb.pop_front(); w = instr_of(e);
          if (PCD !== e || PCPlus4D !== e + 32'd4 || InstrD !== w || opD !== w[6:0]) begin
            n_bad++; $display("FAIL bp_data: PCD=%h InstrD=%h, expected PCD=%h InstrD=%h", PCD, InstrD, e, w);
          end
        end
      end
      if (k == 3 || k == 5) begin
        StallD = (k == 3);
        #1;
      end
      if (k >= 3 && k <= 5) begin
        n_cmp++;
        if (imem_req !== 1'b0) begin
          n_bad++; $display("FAIL bp_req_blocked: cycle %0d req=%b, expected 0", k, imem_req);
        end
      end
      if (k == 6) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
          n_bad++; $display("FAIL bp_resume_req: req=%b addr=%h, expected 1 0000000c", imem_req, imem_addr);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL bp_missing: %0d entries left, expected 0", sb.size());
    end
  endtask

  task automatic test_redirect_wait;
    logic [31:0] e, w;
    do_reset();
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    sb.push_back(32'h100);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (ValidD && ld) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL redir_extra: PCD=%h, none expected", PCD);
        end else begin
          e = sb.pop_front(); w = instr_of(e);
          if (PCD !== e || PCPlus4D !== e + 32'd4 || InstrD !== w) begin
            n_bad++; $display("FAIL redir_data: PCD=%h InstrD=%h, expected PCD=%h InstrD=%h", PCD, InstrD, e, w);
          end
        end
      end
      if (k == 4) lat = 3;
      if (k == 5) begin
        PCSrcE = 1; PCTargetE = 32'h100; FlushD = 1;
      end
      if (k == 6) begin
        n_cmp++;
        if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'hC || imem_addr !== 32'h100 || imem_req !== 1'b0) begin
          n_bad++; $display("FAIL redir_flush: ValidD=%b InstrD=%h PCD=%h addr=%h req=%b, expected 0 %h 0000000c 00000100 0",
                            ValidD, InstrD, PCD, imem_addr, imem_req, NOP);
        end
        PCSrcE = 0; FlushD = 0; lat = 1;
      end
      if (k == 8) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
          n_bad++; $display("FAIL redir_target_req: req=%b addr=%h, expected 1 00000100", imem_req, imem_addr);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL redir_missing: %0d entries left, expected 0", sb.size());
    end
  endtask

  task automatic test_slow_grant;
    logic [31:0] e, w;
    do_reset();
    gnt_en = 0;
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (ValidD && ld) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL gnt_extra: PCD=%h, none expected", PCD);
        end else begin
          e = sb.pop_front(); w = instr_of(e);
          if (PCD !== e || InstrD !== w) begin
            n_bad++; $display("FAIL gnt_data: PCD=%h InstrD=%h, expected PCD=%h InstrD=%h", PCD, InstrD, e, w);
          end
        end
      end
      if (k <= 3) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          n_bad++; $display("FAIL gnt_hold: cycle %0d req=%b addr=%h, expected 1 00000000", k, imem_req, imem_addr);
        end
        if (k == 3) gnt_en = 1;
      end
      if (k == 4) begin
        n_cmp++;
        if (imem_addr !== 32'h4) begin
          n_bad++; $display("FAIL gnt_pc_advance: addr=%h, expected 00000004", imem_addr);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL gnt_missing: %0d entries left, expected 0", sb.size());
    end
  endtask

  task automatic test_stallf_redirect;
    logic [31:0] e, w;
    do_reset();
    StallF = 1; PCSrcE = 1; PCTargetE = 32'h200;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++; $display("FAIL sf_no_req: req=%b, expected 0", imem_req);
    end
    sb.push_back(32'h200);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (ValidD && ld) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL sf_extra: PCD=%h, none expected", PCD);
        end else begin
          e = sb.pop_front(); w = instr_of(e);
          if (PCD !== e || PCPlus4D !== e + 32'd4 || InstrD !== w) begin
            n_bad++; $display("FAIL sf_data: PCD=%h InstrD=%h, expected PCD=%h InstrD=%h", PCD, InstrD, e, w);
          end
        end
      end
      if (k == 1) PCSrcE = 0;
      if (k == 1 || k == 2) begin
        n_cmp++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h200) begin
          n_bad++; $display("FAIL sf_frozen: cycle %0d req=%b addr=%h, expected 0 00000200", k, imem_req, imem_addr);
        end
      end
      if (k == 3) begin
        StallF = 0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
          n_bad++; $display("FAIL sf_release_req: req=%b addr=%h, expected 1 00000200", imem_req, imem_addr);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (imem_addr !== 32'h204) begin
          n_bad++; $display("FAIL sf_next_pc: addr=%h, expected 00000204", imem_addr);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL sf_missing: %0d entries left, expected 0", sb.size());
    end
  endtask

  task automatic test_mid_reset;
    logic [31:0] e, w;
    do_reset();
    sb.push_back(32'h0);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (ValidD && ld) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL mrst_extra: PCD=%h InstrD=%h, none expected", PCD, InstrD);
        end else begin
          e = sb.pop_front(); w = instr_of(e);
          if (PCD !== e || InstrD !== w) begin
            n_bad++; $display("FAIL mrst_data: PCD=%h InstrD=%h, expected PCD=%h InstrD=%h", PCD, InstrD, e, w);
          end
        end
      end
      if (k == 1) lat = 3;
      if (k == 2) begin
        reset = 1;
        #1;
        n_cmp++;
        if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
          n_bad++; $display("FAIL mrst_async: ValidD=%b InstrD=%h PCD=%h PC4=%h req=%b addr=%h, expected 0 %h 0 0 0 0",
                            ValidD, InstrD, PCD, PCPlus4D, imem_req, imem_addr, NOP);
        end
        sb.push_back(32'h0);
      end
      if (k == 3) begin
        reset = 0; gnt_en = 0; inj_rvalid = 1; inj_rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          n_bad++; $display("FAIL mrst_issue: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (ValidD !== 1'b0 || InstrD !== NOP || imem_addr !== 32'h0) begin
          n_bad++; $display("FAIL mrst_late_rvalid: ValidD=%b InstrD=%h addr=%h, expected 0 %h 00000000", ValidD, InstrD, imem_addr, NOP);
        end
        inj_rvalid = 0; gnt_en = 1; lat = 1;
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL mrst_missing: %0d entries left, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_slow_grant();
    test_stallf_redirect();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Pipelined RISC-V instruction-fetch stage. It feeds the Decode stage and the decode control logic.
- Owns the program counter (PCF).
- Issues requests to a variable-latency instruction memory over a req/gnt/rvalid handshake.
- Holds the IF/ID pipeline register and exposes op/funct3/funct7b5 to the control unit.
- Absorbs memory/Decode timing mismatch with a one-entry skid buffer.
- Applies hazard-unit stall/flush and Execute-stage redirects (PCSrcE/PCTargetE).

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PCF value after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
StallF  input  1  hazard unit: freeze PCF, issue no new request
StallD  input  1  hazard unit: hold IF/ID register
FlushD  input  1  hazard unit: load bubble into IF/ID
PCSrcE  input  1  Execute redirect (branch taken / jump)
PCTargetE  input  XLEN  redirect target
imem_req  output  1  request valid
imem_addr  output  XLEN  request address (= PCF)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid; responses in order, at least 1 cycle after gnt
imem_rdata  input  32  response instruction
InstrD  output  32  IF/ID instruction
PCD  output  XLEN  IF/ID PC
PCPlus4D  output  XLEN  IF/ID PC+4
ValidD  output  1  IF/ID holds a real instruction
opD  output  7  InstrD[6:0]
funct3D  output  3  InstrD[14:12]
funct7b5D  output  1  InstrD[30]

Behaviour:
- Reset (async, any state, including mid-transaction):
  - PCF=RESET_PC, state=ISSUE, buffer empty, drop flag=0.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - imem_req=0 while reset is asserted.
  - The instruction memory shares the reset.
- At most one outstanding request.
- State ISSUE:
  - imem_req = !StallF && buffer empty && !PCSrcE.
  - imem_addr = PCF, held stable until gnt.
  - On req&&gnt: latch PC_inflight=PCF, PCF<=PCF+4 (mod 2^XLEN, wraps), go to WAIT.
- State WAIT:
  - Response accepted only on imem_rvalid in WAIT; rvalid in ISSUE is ignored.
  - If drop flag=1, discard the response, clear drop, go to ISSUE.
  - Otherwise, if the IF/ID register loads this cycle, write {rdata, PC_inflight} into it. Else write into the buffer.
  - Same-cycle reissue: if the data was consumed directly and !StallF && !PCSrcE, imem_req=1 in the same cycle. This makes throughput 1 instr/cycle with a 1-cycle memory. If gnt, stay in WAIT with the new PC_inflight; else go to ISSUE.
- IF/ID load rule, evaluated each cycle, priority top-down:
  - FlushD: bubble (NOP_INSTR, ValidD=0, PCD/PCPlus4D unchanged), regardless of StallD.
  - StallD: hold.
  - Buffer full: load buffer, empty it.
  - Accepted response (not dropped): load it, ValidD=1, PCPlus4D=PC+4.
  - Otherwise: bubble.
- PCSrcE=1 (priority over StallF and StallD for the PC path):
  - PCF<=PCTargetE; buffer emptied.
  - If a request is outstanding and rvalid is not present this cycle, set drop flag.
  - If rvalid is present this cycle, discard it.
  - No request is issued this cycle. The next request, to PCTargetE, is issued the following cycle.
  - The hazard unit asserts FlushD alongside; the block does not self-flush IF/ID.
- Buffer boundaries:
  - Never written when full; full implies no request is issued, so overflow cannot occur.
  - Simultaneous buffer drain into IF/ID and new response is impossible, because no request is outstanding while the buffer is full.
- Latency, 1-cycle memory: first valid InstrD appears 2 cycles after reset deassertion (ISSUE+gnt at cycle 0, rvalid at cycle 1, InstrD at cycle 2).

Decomposition:
- riscv_pkg holds:
  - XLEN
  - NOP_INSTR
  - fetch state enum {ISSUE, WAIT}
  - opcode field slice positions (OP_LSB/MSB, F3_LSB/MSB, F7B5_BIT), shared with the control logic
- Sub-module fetch_skid_buffer: one-entry {instr, pc} register with push, pop, flush and full.
- IF/ID register uses the team's enable/reset flop primitive.

Test Plan:
- Sequential run: reset release, memory with gnt=1 and rvalid 1 cycle later returning PC-tagged words → PCD=0,4,8,12 on consecutive cycles, ValidD=1 from cycle 2, opD=InstrD[6:0].
- Back-pressure: StallD=1 for 2 cycles while the response for PC 0x8 arrives → response buffered, no request issued while buffer full. After release, PCD=0x8 then 0xC, no loss or duplicate.
- Redirect in WAIT: PCSrcE=1 with PCTargetE=0x100 while the 0x10 request is outstanding, FlushD=1 → 0x10 response discarded, ValidD=0, next imem_addr=0x100, then PCD=0x100.
- Slow grant: gnt low for 3 cycles → imem_req held 1 and imem_addr stable at PCF. PCF advances only after gnt.
- StallF with redirect: StallF=1 and PCSrcE=1 together → PCF=PCTargetE; request to target issued after StallF drops.
- Mid-transaction reset: assert reset in WAIT, late rvalid after release while in ISSUE → rvalid ignored, imem_addr=RESET_PC, ValidD=0, InstrD=0x00000013.
